// File: rtl/stack_tracker_pkg.sv
// rtl/stack_tracker_pkg.sv - shared FSM state type and default geometry for the stack tracker
package stack_tracker_pkg;

  localparam int X_W_DEF       = 9;
  localparam int SIZE_W_DEF    = 4;
  localparam int UNIT_LOG2_DEF = 3;
  localparam int DEPTH_DEF     = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_COMMIT = 3'd2,
    ST_OVER   = 3'd3,
    ST_WON    = 3'd4
  } state_e;

endpackage

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - row storage for stacked block spans, synchronous write, asynchronous read
module stack_mem #(
  parameter int DEPTH = 16,
  parameter int DW    = 18,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/stack_tracker.sv
// rtl/stack_tracker.sv - judges block placements against the top of the stack and records hits
module stack_tracker
  import stack_tracker_pkg::*;
#(
  parameter int  X_W       = X_W_DEF,
  parameter int  SIZE_W    = SIZE_W_DEF,
  parameter int  UNIT_LOG2 = UNIT_LOG2_DEF,
  parameter int  DEPTH     = DEPTH_DEF,
  localparam int H_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              restart,
  input  logic              place_valid,
  output logic              place_ready,
  input  logic [X_W-1:0]    curr_block_start,
  input  logic [X_W-1:0]    curr_block_end,
  output logic [X_W-1:0]    prev_block_start,
  output logic [X_W-1:0]    prev_block_end,
  output logic [SIZE_W-1:0] prev_block_size,
  output logic [H_W-1:0]    height,
  output logic              result_valid,
  output logic              result_hit,
  output logic              game_over,
  output logic              game_won,
  input  logic [H_W-1:0]    rd_row,
  output logic [X_W-1:0]    rd_start,
  output logic [X_W-1:0]    rd_end
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [X_W:0] SIZE_MAX = (X_W+1)'((1 << SIZE_W) - 1);

  state_e              state_q, state_d;
  logic [X_W-1:0]      cap_start_q, cap_start_d, cap_end_q, cap_end_d;
  logic [X_W-1:0]      prev_start_q, prev_start_d, prev_end_q, prev_end_d;
  logic [SIZE_W-1:0]   prev_size_q, prev_size_d;
  logic [H_W-1:0]      height_q, height_d;
  logic                rv_q, rv_d, rh_q, rh_d, over_q, over_d, won_q, won_d;

  logic [X_W-1:0]      trim_start, trim_end;
  logic [X_W:0]        trim_span, trim_units;
  logic [SIZE_W-1:0]   trim_size;
  logic                miss, wr_en;
  logic [2*X_W-1:0]    rd_data;

  // Span width needs one extra bit: a full-width block is 2^X_W pixels wide.
  always_comb begin
    trim_start = cap_start_q;
    trim_end   = cap_end_q;
    if (height_q != '0) begin
      trim_start = (cap_start_q > prev_start_q) ? cap_start_q : prev_start_q;
      trim_end   = (cap_end_q < prev_end_q) ? cap_end_q : prev_end_q;
    end
    trim_span  = {1'b0, trim_end} - {1'b0, trim_start} + (X_W+1)'(1);
    trim_units = trim_span >> UNIT_LOG2;
    trim_size  = (trim_units > SIZE_MAX) ? SIZE_MAX[SIZE_W-1:0] : trim_units[SIZE_W-1:0];
    miss = (cap_start_q > cap_end_q)
        || ((height_q != '0) && ((cap_start_q > prev_end_q) || (cap_end_q < prev_start_q)))
        || (trim_size == '0);
  end

  assign wr_en = (state_q == ST_CHECK) && !miss && !restart;

  stack_mem #(.DEPTH(DEPTH), .DW(2 * X_W), .AW(AW)) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (height_q[AW-1:0]),
    .wr_data_i ({trim_end, trim_start}),
    .rd_addr_i (rd_row[AW-1:0]),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    cap_start_d  = cap_start_q;
    cap_end_d    = cap_end_q;
    prev_start_d = prev_start_q;
    prev_end_d   = prev_end_q;
    prev_size_d  = prev_size_q;
    height_d     = height_q;
    rv_d         = 1'b0;
    rh_d         = rh_q;
    over_d       = over_q;
    won_d        = won_q;
    if (restart) begin
      state_d      = ST_IDLE;
      prev_start_d = '0;
      prev_end_d   = '0;
      prev_size_d  = '0;
      height_d     = '0;
      rh_d         = 1'b0;
      over_d       = 1'b0;
      won_d        = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (place_valid) begin
            cap_start_d = curr_block_start;
            cap_end_d   = curr_block_end;
            state_d     = ST_CHECK;
          end
        end
        ST_CHECK: begin
          rv_d = 1'b1;
          if (miss) begin
            rh_d    = 1'b0;
            over_d  = 1'b1;
            state_d = ST_OVER;
          end else begin
            rh_d         = 1'b1;
            prev_start_d = trim_start;
            prev_end_d   = trim_end;
            prev_size_d  = trim_size;
            height_d     = height_q + H_W'(1);
            state_d      = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (height_q == H_W'(DEPTH)) begin
            won_d   = 1'b1;
            state_d = ST_WON;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_OVER, ST_WON: state_d = state_q;
        default:         state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cap_start_q  <= '0;
      cap_end_q    <= '0;
      prev_start_q <= '0;
      prev_end_q   <= '0;
      prev_size_q  <= '0;
      height_q     <= '0;
      rv_q         <= 1'b0;
      rh_q         <= 1'b0;
      over_q       <= 1'b0;
      won_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_start_q  <= cap_start_d;
      cap_end_q    <= cap_end_d;
      prev_start_q <= prev_start_d;
      prev_end_q   <= prev_end_d;
      prev_size_q  <= prev_size_d;
      height_q     <= height_d;
      rv_q         <= rv_d;
      rh_q         <= rh_d;
      over_q       <= over_d;
      won_q        <= won_d;
    end
  end

  assign place_ready      = (state_q == ST_IDLE);
  assign prev_block_start = prev_start_q;
  assign prev_block_end   = prev_end_q;
  assign prev_block_size  = prev_size_q;
  assign height           = height_q;
  assign result_valid     = rv_q;
  assign result_hit       = rh_q;
  assign game_over        = over_q;
  assign game_won         = won_q;
  assign rd_start         = (rd_row < height_q) ? rd_data[X_W-1:0] : '0;
  assign rd_end           = (rd_row < height_q) ? rd_data[2*X_W-1:X_W] : '0;

endmodule
